// File: rtl/controlador_varredura_display.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment
// display sharing one code-to-segment decoder. Each digit slot is a short
// blanking gap followed by the lit period; new content takes effect only at
// frame boundaries (or immediately while idle).
module controlador_varredura_display #(
    parameter int N_DIGITS         = 4,
    parameter int PRESCALE         = 50000,
    parameter int BLANK_CYCLES     = 16,
    parameter bit DIGIT_ACTIVE_LOW = 1'b1
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        ENABLE,
    input  logic                        LOAD,
    input  logic [4*N_DIGITS-1:0]       VALUES,
    input  logic [N_DIGITS-1:0]         BLANK_MASK,
    output logic [3:0]                  D7SEG,
    output logic [N_DIGITS-1:0]         DIGIT_SEL,
    output logic [$clog2(N_DIGITS)-1:0] CUR_DIGIT,
    output logic                        LOAD_ACK,
    output logic                        FRAME_TICK
);

    localparam int IDX_W = $clog2(N_DIGITS);
    localparam int CNT_W = $clog2(PRESCALE);

    // Terminal counts of the blank and show phases inside one slot
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(PRESCALE - BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

    localparam logic                OFF_LVL = DIGIT_ACTIVE_LOW;
    localparam logic                ON_LVL  = ~DIGIT_ACTIVE_LOW;
    localparam logic [N_DIGITS-1:0] ALL_OFF = {N_DIGITS{OFF_LVL}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;

    logic [4*N_DIGITS-1:0]   act_val_q, act_val_d;
    logic [N_DIGITS-1:0]     act_mask_q, act_mask_d;
    logic [4*N_DIGITS-1:0]   pend_val_q, pend_val_d;
    logic [N_DIGITS-1:0]     pend_mask_q, pend_mask_d;
    logic                    pend_q, pend_d;

    logic [3:0]              d7seg_q, d7seg_d;
    logic [N_DIGITS-1:0]     digit_sel_q, digit_sel_d;
    logic [IDX_W-1:0]        cur_digit_q, cur_digit_d;
    logic                    load_ack_q, load_ack_d;
    logic                    frame_tick_q, frame_tick_d;

    logic                    wrap;
    logic                    commit;

    // Pick the 4-bit code of digit i out of the packed value word
    function automatic logic [3:0] nibble_at(input logic [4*N_DIGITS-1:0] v,
                                             input logic [IDX_W-1:0]      i);
        logic [3:0] r;
        r = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (i == IDX_W'(k)) begin
                r = v[4*k +: 4];
            end
        end
        return r;
    endfunction

    // Enable vector with only digit i lit, in the configured polarity
    function automatic logic [N_DIGITS-1:0] digit_on(input logic [IDX_W-1:0] i);
        logic [N_DIGITS-1:0] r;
        r = ALL_OFF;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (i == IDX_W'(k)) begin
                r[k] = ON_LVL;
            end
        end
        return r;
    endfunction

    // Scan sequencing: IDLE -> (BLANK -> SHOW) per digit, wrapping each frame
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wrap    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (ENABLE) begin
                    state_d = ST_BLANK;
                end
            end
            ST_BLANK: begin
                if (!ENABLE) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (cnt_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SHOW: begin
                if (!ENABLE) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (cnt_q == SHOW_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    wrap    = (idx_q == IDX_LAST);
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Content staging: LOAD fills pending; pending (or a coincident LOAD)
    // becomes active while idle or on the frame wrap. A request left pending
    // when scanning stops is committed on the first idle cycle.
    always_comb begin
        commit      = (LOAD || pend_q) && ((state_q == ST_IDLE) || wrap);
        act_val_d   = act_val_q;
        act_mask_d  = act_mask_q;
        pend_val_d  = pend_val_q;
        pend_mask_d = pend_mask_q;
        pend_d      = pend_q;
        if (commit) begin
            act_val_d  = LOAD ? VALUES     : pend_val_q;
            act_mask_d = LOAD ? BLANK_MASK : pend_mask_q;
            pend_d     = 1'b0;
        end else if (LOAD) begin
            pend_val_d  = VALUES;
            pend_mask_d = BLANK_MASK;
            pend_d      = 1'b1;
        end
    end

    // Output decode from the next state so every output is a flop that
    // matches the state it accompanies; the code is stable through BLANK
    // before the digit enable turns on in SHOW
    always_comb begin
        d7seg_d     = nibble_at(act_val_d, idx_d);
        digit_sel_d = ALL_OFF;
        if ((state_d == ST_SHOW) && !act_mask_d[idx_d]) begin
            digit_sel_d = digit_on(idx_d);
        end
        cur_digit_d  = (state_d == ST_IDLE) ? '0 : idx_d;
        load_ack_d   = commit;
        frame_tick_d = wrap;
    end

    // State, content and output registers with asynchronous reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            act_val_q    <= '0;
            act_mask_q   <= '1;
            pend_val_q   <= '0;
            pend_mask_q  <= '0;
            pend_q       <= 1'b0;
            d7seg_q      <= '0;
            digit_sel_q  <= ALL_OFF;
            cur_digit_q  <= '0;
            load_ack_q   <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            act_val_q    <= act_val_d;
            act_mask_q   <= act_mask_d;
            pend_val_q   <= pend_val_d;
            pend_mask_q  <= pend_mask_d;
            pend_q       <= pend_d;
            d7seg_q      <= d7seg_d;
            digit_sel_q  <= digit_sel_d;
            cur_digit_q  <= cur_digit_d;
            load_ack_q   <= load_ack_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign D7SEG      = d7seg_q;
    assign DIGIT_SEL  = digit_sel_q;
    assign CUR_DIGIT  = cur_digit_q;
    assign LOAD_ACK   = load_ack_q;
    assign FRAME_TICK = frame_tick_q;

endmodule

// File: tb/tb_controlador_varredura_display.sv
// Bench for controlador_varredura_display (4 digits, 8-cycle slots, 2 blank).
// Stimulus pushes per-cycle expected outputs tagged with their cycle number;
// a negedge monitor pops and compares them as the cycles come up.
module tb_controlador_varredura_display;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ENABLE;
    logic        LOAD;
    logic [15:0] VALUES;
    logic [3:0]  BLANK_MASK;
    logic [3:0]  D7SEG;
    logic [3:0]  DIGIT_SEL;
    logic [1:0]  CUR_DIGIT;
    logic        LOAD_ACK;
    logic        FRAME_TICK;

    controlador_varredura_display #(
        .N_DIGITS(4),
        .PRESCALE(8),
        .BLANK_CYCLES(2),
        .DIGIT_ACTIVE_LOW(1'b1)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .ENABLE(ENABLE),
        .LOAD(LOAD),
        .VALUES(VALUES),
        .BLANK_MASK(BLANK_MASK),
        .D7SEG(D7SEG),
        .DIGIT_SEL(DIGIT_SEL),
        .CUR_DIGIT(CUR_DIGIT),
        .LOAD_ACK(LOAD_ACK),
        .FRAME_TICK(FRAME_TICK)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         cyc;
        logic [3:0] d7;
        logic [3:0] sel;
        logic [1:0] cur;
        logic       ack;
        logic       tick;
        string      tag;
    } exp_t;

    exp_t expq[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Expected outputs of one digit slot (or its first len cycles)
    task automatic exp_slot(input int start, input int d, input logic [3:0] val,
                            input bit masked, input bit ack, input bit tick,
                            input int len, input string tag);
        for (int k = 0; k < len; k++) begin
            exp_t r;
            r.cyc  = start + k;
            r.d7   = val;
            r.cur  = 2'(d);
            r.ack  = (k == 0) && ack;
            r.tick = (k == 0) && tick;
            r.sel  = (k < 2 || masked) ? 4'hF : 4'(~(4'b0001 << d));
            r.tag  = tag;
            expq.push_back(r);
        end
    endtask

    // Expected outputs of a whole 32-cycle frame
    task automatic exp_frame(input int start, input logic [15:0] vals,
                             input logic [3:0] mask, input bit ack, input bit tick,
                             input string tag);
        for (int d = 0; d < 4; d++) begin
            exp_slot(start + 8*d, d, vals[4*d +: 4], mask[d],
                     (d == 0) && ack, (d == 0) && tick, 8, tag);
        end
    endtask

    // Expected outputs while idle
    task automatic exp_idle(input int start, input int n, input logic [3:0] d7,
                            input bit ack, input string tag);
        for (int k = 0; k < n; k++) begin
            exp_t r;
            r.cyc  = start + k;
            r.d7   = d7;
            r.sel  = 4'hF;
            r.cur  = 2'd0;
            r.ack  = (k == 0) && ack;
            r.tick = 1'b0;
            r.tag  = tag;
            expq.push_back(r);
        end
    endtask

    // Immediate check of the outputs (used around asynchronous reset)
    task automatic chk_now(input string tag, input logic [3:0] d7, input logic [3:0] sel,
                           input logic [1:0] cur, input logic ack, input logic tick);
        checks++;
        if (D7SEG !== d7 || DIGIT_SEL !== sel || CUR_DIGIT !== cur ||
            LOAD_ACK !== ack || FRAME_TICK !== tick) begin
            errors++;
            $display("FAIL %s t=%0t got d7=%h sel=%b cur=%0d ack=%b tick=%b want d7=%h sel=%b cur=%0d ack=%b tick=%b",
                     tag, $time, D7SEG, DIGIT_SEL, CUR_DIGIT, LOAD_ACK, FRAME_TICK,
                     d7, sel, cur, ack, tick);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    // Monitor: compare every scheduled cycle away from the active edge
    exp_t m;
    always @(negedge CLK) begin
        while (expq.size() > 0 && expq[0].cyc < cyc) begin
            m = expq.pop_front();
            checks++;
            errors++;
            $display("FAIL %s missed cycle %0d (now %0d)", m.tag, m.cyc, cyc);
        end
        if (expq.size() > 0 && expq[0].cyc == cyc) begin
            m = expq.pop_front();
            checks++;
            if (D7SEG !== m.d7 || DIGIT_SEL !== m.sel || CUR_DIGIT !== m.cur ||
                LOAD_ACK !== m.ack || FRAME_TICK !== m.tick) begin
                errors++;
                $display("FAIL %s cyc=%0d got d7=%h sel=%b cur=%0d ack=%b tick=%b want d7=%h sel=%b cur=%0d ack=%b tick=%b",
                         m.tag, cyc, D7SEG, DIGIT_SEL, CUR_DIGIT, LOAD_ACK, FRAME_TICK,
                         m.d7, m.sel, m.cur, m.ack, m.tick);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, f, r, lim;
        RST        = 1'b1;
        ENABLE     = 1'b0;
        LOAD       = 1'b0;
        VALUES     = 16'h0000;
        BLANK_MASK = 4'h0;

        repeat (2) @(posedge CLK);
        #1;
        chk_now("reset_state", 4'h0, 4'hF, 2'd0, 1'b0, 1'b0);
        RST = 1'b0;
        step();

        // Load while idle: commit on the same edge, then scan 4,3,2,1
        LOAD   = 1'b1;
        VALUES = 16'h1234;
        exp_idle(cyc + 1, 1, 4'h4, 1'b1, "idle_load");
        step();
        LOAD   = 1'b0;
        ENABLE = 1'b1;
        s = cyc + 1;
        exp_frame(s, 16'h1234, 4'h0, 1'b0, 1'b0, "frame_1234");

        // Load during slot 1: current frame unchanged, new frame D,C,B,A
        wait_until(s + 10);
        LOAD   = 1'b1;
        VALUES = 16'hABCD;
        exp_frame(s + 32, 16'hABCD, 4'h0, 1'b1, 1'b1, "frame_abcd");
        step();
        LOAD = 1'b0;
        f = s + 32;

        // Two loads in one frame merge into a single commit
        wait_until(f + 3);
        LOAD   = 1'b1;
        VALUES = 16'h1111;
        step();
        LOAD = 1'b0;
        wait_until(f + 20);
        LOAD   = 1'b1;
        VALUES = 16'h5555;
        exp_frame(f + 32, 16'h5555, 4'h0, 1'b1, 1'b1, "frame_5555");
        step();
        LOAD = 1'b0;
        f = f + 32;

        // Load exactly on the wrap edge bypasses pending
        wait_until(f + 31);
        LOAD   = 1'b1;
        VALUES = 16'h9999;
        exp_frame(f + 32, 16'h9999, 4'h0, 1'b1, 1'b1, "frame_9999");
        step();
        LOAD = 1'b0;
        f = f + 32;

        // Masked digit 2 stays dark but keeps its slot
        wait_until(f + 5);
        LOAD       = 1'b1;
        VALUES     = 16'h7654;
        BLANK_MASK = 4'b0100;
        step();
        LOAD = 1'b0;
        f = f + 32;
        exp_slot(f,     0, 4'h4, 1'b0, 1'b1, 1'b1, 8, "mask_s0");
        exp_slot(f + 8, 1, 4'h5, 1'b0, 1'b0, 1'b0, 6, "mask_s1");

        // Drop enable in slot 1 SHOW, idle quietly, then restart at digit 0
        wait_until(f + 13);
        ENABLE = 1'b0;
        exp_idle(f + 14, 10, 4'h4, 1'b0, "disabled");
        wait_until(f + 23);
        ENABLE = 1'b1;
        r = f + 24;
        exp_frame(r, 16'h7654, 4'b0100, 1'b0, 1'b0, "restart");
        exp_slot(r + 32, 0, 4'h4, 1'b0, 1'b0, 1'b1, 8, "restart2_s0");
        exp_slot(r + 40, 1, 4'h5, 1'b0, 1'b0, 1'b0, 8, "restart2_s1");
        exp_slot(r + 48, 2, 4'h6, 1'b1, 1'b0, 1'b0, 5, "restart2_s2");

        // Asynchronous reset in the middle of slot 2 SHOW
        wait_until(r + 52);
        #6;
        RST = 1'b1;
        #1;
        chk_now("async_reset", 4'h0, 4'hF, 2'd0, 1'b0, 1'b0);
        step();
        chk_now("reset_held", 4'h0, 4'hF, 2'd0, 1'b0, 1'b0);
        RST = 1'b0;
        s = cyc + 1;
        exp_frame(s, 16'h0000, 4'hF, 1'b0, 1'b0, "dark_after_reset");
        exp_slot(s + 32, 0, 4'h0, 1'b1, 1'b0, 1'b1, 1, "dark_wrap");

        lim = cyc + 100;
        while (expq.size() > 0 && cyc < lim) step();
        if (expq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", expq.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
